// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns a stream of received UART bytes into decoded commands and queues a
//   one-byte acknowledgement for the UART transmitter.
//
//   A line is one command letter (R, S, C or T, either case), then up to
//   MAX_DIGITS decimal digits, then CR or LF.
//   Each command maps to a code:
//     R -> RUN (0), S -> STOP (1), C -> CLEAR (2), T -> SET (3).
//   T needs at least one digit. R, S and C take no digits.
//
//   Every good line pulses cmd_valid and queues 'K'.
//   Every malformed line pulses cmd_err once and queues '?'.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   rx_data    byte from the UART receiver
//   rx_done    one-cycle strobe, rx_data valid this cycle
//   tx_busy    UART transmitter busy
//   cmd_valid  one-cycle pulse, command decoded
//   cmd_code   decoded command, held between cmd_valid pulses
//   cmd_arg    SET argument in binary (0 for R/S/C), held between pulses
//   cmd_err    one-cycle pulse, malformed line
//   tx_start   one-cycle send request to the transmitter
//   tx_data    response byte, valid while tx_start is high
module uart_cmd_parser #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        tx_busy,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic [13:0] cmd_arg,
  output logic        cmd_err,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  localparam int CNT_W = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  localparam logic [1:0] CODE_RUN   = 2'd0;
  localparam logic [1:0] CODE_STOP  = 2'd1;
  localparam logic [1:0] CODE_CLEAR = 2'd2;
  localparam logic [1:0] CODE_SET   = 2'd3;

  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h3F;

  typedef enum logic [1:0] {IDLE, ARG, DISCARD} parse_state_e;
  typedef enum logic {SEND_IDLE, SEND_WAIT} send_state_e;

  parse_state_e      state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [13:0]       acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_err_q, cmd_err_d;
  logic [1:0]        cmd_code_q, cmd_code_d;
  logic [13:0]       cmd_arg_q, cmd_arg_d;

  send_state_e       send_state_q, send_state_d;
  logic              wait_done_q, wait_done_d;
  logic              pending_q, pending_d;
  logic [7:0]        pend_byte_q, pend_byte_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic              is_term;
  logic              is_digit;
  logic              letter_ok;
  logic [1:0]        letter_code;
  logic              line_good;
  logic              consume;

  // Byte classification. Clearing bit 5 folds lower-case letters onto
  // upper case. Only the two case variants of a letter map to the same value.
  always_comb begin
    is_term     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    letter_ok   = 1'b1;
    letter_code = CODE_RUN;
    case (rx_data & 8'hDF)
      8'h52:   letter_code = CODE_RUN;
      8'h53:   letter_code = CODE_STOP;
      8'h43:   letter_code = CODE_CLEAR;
      8'h54:   letter_code = CODE_SET;
      default: letter_ok = 1'b0;
    endcase
  end

  // A line is good when SET has at least one digit,
  // or when RUN/STOP/CLEAR has no digits.
  assign line_good = (code_q == CODE_SET) ? (cnt_q != '0) : (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    cmd_code_d  = cmd_code_q;
    cmd_arg_d   = cmd_arg_q;
    if (rx_done) begin
      case (state_q)
        IDLE: begin
          if (letter_ok) begin
            state_d = ARG;
            code_d  = letter_code;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (!is_term) begin
            cmd_err_d = 1'b1;
            state_d   = DISCARD;
          end
        end
        ARG: begin
          if (is_digit) begin
            if (cnt_q == CNT_MAX) begin
              cmd_err_d = 1'b1;
              state_d   = DISCARD;
            end else begin
              acc_d = acc_q * 14'd10 + 14'(rx_data[3:0]);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            state_d = IDLE;
            if (line_good) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = code_q;
              cmd_arg_d   = (code_q == CODE_SET) ? acc_q : 14'd0;
            end else begin
              cmd_err_d = 1'b1;
            end
          end else begin
            cmd_err_d = 1'b1;
            state_d   = DISCARD;
          end
        end
        DISCARD: begin
          if (is_term) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The single pending slot is refilled from this cycle's result pulse.
  // A pulse that lands in the cycle the slot is drained keeps the slot
  // full for the next send.
  assign consume = (send_state_q == SEND_IDLE) && pending_q && !tx_busy;

  always_comb begin
    send_state_d = send_state_q;
    wait_done_d  = wait_done_q;
    pending_d    = pending_q && !consume;
    pend_byte_d  = pend_byte_q;
    tx_start_d   = consume;
    tx_data_d    = consume ? pend_byte_q : tx_data_q;
    if (cmd_valid_q) begin
      pending_d   = 1'b1;
      pend_byte_d = RESP_OK;
    end else if (cmd_err_q) begin
      pending_d   = 1'b1;
      pend_byte_d = RESP_ERR;
    end
    case (send_state_q)
      SEND_IDLE: begin
        if (consume) begin
          send_state_d = SEND_WAIT;
          wait_done_d  = 1'b0;
        end
      end
      SEND_WAIT: begin
        // The first cycle in this state is always spent waiting.
        // This gives the transmitter time to raise tx_busy.
        if (!wait_done_q) wait_done_d = 1'b1;
        else if (!tx_busy) send_state_d = SEND_IDLE;
      end
      default: send_state_d = SEND_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      code_q       <= CODE_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      cmd_code_q   <= CODE_RUN;
      cmd_arg_q    <= '0;
      send_state_q <= SEND_IDLE;
      wait_done_q  <= 1'b0;
      pending_q    <= 1'b0;
      pend_byte_q  <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_err_q    <= cmd_err_d;
      cmd_code_q   <= cmd_code_d;
      cmd_arg_q    <= cmd_arg_d;
      send_state_q <= send_state_d;
      wait_done_q  <= wait_done_d;
      pending_q    <= pending_d;
      pend_byte_q  <= pend_byte_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_arg   = cmd_arg_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Drives byte streams into uart_cmd_parser.
//   Compares every cycle against a line-level reference model.
//
//   The model keeps the bytes of the current line.
//   A line raises an error on the byte that first makes it an illegal prefix.
//   A complete line is evaluated when its terminator arrives.
//   Responses are kept as a time-stamped list.
//   Each tx_start must carry the newest response that is at least two
//   cycles old.
module tb_uart_cmd_parser;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_busy = 1'b0;
  logic        cmd_valid;
  logic [1:0]  cmd_code;
  logic [13:0] cmd_arg;
  logic        cmd_err;
  logic        tx_start;
  logic [7:0]  tx_data;

  uart_cmd_parser #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_err(cmd_err),
    .tx_start(tx_start), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  byte unsigned line_q[$];
  logic [1:0]   exp_code = 2'd0;
  logic [13:0]  exp_arg = 14'd0;

  byte unsigned resp_byte[$];
  int           resp_cyc[$];
  int           next_unsent = 0;
  int           last_start_cyc = -100;
  int           busy_cnt = 0;
  bit           force_busy = 1'b0;
  int           tx_count = 0;
  int           valid_seen = 0;
  int           err_seen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  function automatic bit isTerm(input byte unsigned b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic int letterCode(input byte unsigned b);
    byte unsigned u;
    u = (b >= "a" && b <= "z") ? byte'(b - 8'd32) : b;
    if (u == "R") return 0;
    if (u == "S") return 1;
    if (u == "C") return 2;
    if (u == "T") return 3;
    return -1;
  endfunction

  function automatic bit prefixOk(input byte unsigned b[$]);
    if (b.size() == 0) return 1'b1;
    if (letterCode(b[0]) < 0) return 1'b0;
    if (b.size() - 1 > MAXD) return 1'b0;
    for (int i = 1; i < b.size(); i++)
      if (b[i] < "0" || b[i] > "9") return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelByte(input byte unsigned b, output bit ev, output bit ee);
    int lc;
    int n;
    int val;
    bit was_ok;
    ev = 1'b0;
    ee = 1'b0;
    if (isTerm(b)) begin
      if (line_q.size() > 0 && prefixOk(line_q)) begin
        lc  = letterCode(line_q[0]);
        n   = line_q.size() - 1;
        val = 0;
        for (int i = 1; i <= n; i++) val = val * 10 + (int'(line_q[i]) - 48);
        if ((lc == 3) == (n > 0)) begin
          ev       = 1'b1;
          exp_code = 2'(lc);
          exp_arg  = (lc == 3) ? 14'(val) : 14'd0;
        end else begin
          ee = 1'b1;
        end
      end
      line_q.delete();
    end else begin
      was_ok = prefixOk(line_q);
      line_q.push_back(b);
      if (was_ok && !prefixOk(line_q)) ee = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs, step the model, then sample after the edge.
  task automatic applyStimulus(input bit rst_n, input bit done, input byte unsigned data);
    bit ev;
    bit ee;
    bit cur_busy;
    int idx;
    ev = 1'b0;
    ee = 1'b0;
    rst     = rst_n;
    rx_done = done;
    rx_data = done ? data : 8'($urandom_range(0, 255));
    cur_busy = force_busy || (busy_cnt > 0);
    tx_busy = cur_busy;
    if (busy_cnt > 0) busy_cnt--;
    if (!rst_n) begin
      line_q.delete();
      exp_code       = 2'd0;
      exp_arg        = 14'd0;
      next_unsent    = resp_byte.size();
      last_start_cyc = -100;
    end else if (done) begin
      modelByte(data, ev, ee);
    end
    @(negedge clk);
    cyc++;
    checkOutput("cmd_valid", 32'(cmd_valid), 32'(ev));
    checkOutput("cmd_err", 32'(cmd_err), 32'(ee));
    checkOutput("cmd_code", 32'(cmd_code), 32'(exp_code));
    checkOutput("cmd_arg", 32'(cmd_arg), 32'(exp_arg));
    if (cmd_valid === 1'b1) valid_seen++;
    if (cmd_err === 1'b1) err_seen++;
    if (ev) begin resp_byte.push_back(8'h4B); resp_cyc.push_back(cyc); end
    if (ee) begin resp_byte.push_back(8'h3F); resp_cyc.push_back(cyc); end
    if (!rst_n) begin
      checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
      checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    end else if (tx_start === 1'b1) begin
      tx_count++;
      checkOutput("tx_busy_at_start", 32'(cur_busy), 32'd0);
      checkOutput("tx_start_spacing", 32'(cyc - last_start_cyc >= 3), 32'd1);
      idx = -1;
      for (int i = next_unsent; i < resp_byte.size(); i++)
        if (resp_cyc[i] <= cyc - 2) idx = i;
      checkOutput("tx_has_pending", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        checkOutput("tx_data", 32'(tx_data), 32'(resp_byte[idx]));
        next_unsent = idx + 1;
      end
      last_start_cyc = cyc;
      if (!force_busy) busy_cnt = $urandom_range(0, 4);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 8'h00);
  endtask

  task automatic sendText(input string body, input byte unsigned term, input int maxgap);
    for (int i = 0; i < body.len(); i++) begin
      applyStimulus(1'b1, 1'b1, body[i]);
      idle($urandom_range(0, maxgap));
    end
    applyStimulus(1'b1, 1'b1, term);
  endtask

  task automatic randomLine();
    byte unsigned q[$];
    string letters;
    byte unsigned term;
    int kind;
    int nd;
    letters = "RSCTrsct";
    term = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
    kind = $urandom_range(0, 9);
    if (kind <= 7 && kind != 6) q.push_back(letters[$urandom_range(0, 7)]);
    if (kind <= 4) nd = $urandom_range(0, MAXD);
    else if (kind == 5) nd = $urandom_range(MAXD + 1, MAXD + 2);
    else if (kind == 7) nd = $urandom_range(0, 2);
    else nd = 0;
    for (int i = 0; i < nd; i++) q.push_back(8'($urandom_range(48, 57)));
    if (kind == 6) q.push_back(8'($urandom_range(0, 255)));
    if (kind == 7) begin
      q.push_back(8'($urandom_range(33, 126)));
      q.push_back(8'($urandom_range(48, 57)));
    end
    if (kind == 9)
      for (int i = 0; i < $urandom_range(1, 6); i++) q.push_back(8'($urandom_range(0, 255)));
    q.push_back(term);
    for (int i = 0; i < q.size(); i++) begin
      if ($urandom_range(0, 199) == 0) applyStimulus(1'b0, 1'b0, 8'h00);
      if ($urandom_range(0, 15) == 0) busy_cnt = $urandom_range(1, 8);
      applyStimulus(1'b1, 1'b1, q[i]);
      idle($urandom_range(0, 2));
    end
  endtask

  int tx_before;
  int err_before;
  int valid_before;

  initial begin
    // Reset state
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    idle(2);

    // SET with four digits
    tx_before = tx_count;
    sendText("T1234", 8'h0D, 0);
    idle(8);
    checkOutput("t1234_arg", 32'(cmd_arg), 32'd1234);
    checkOutput("t1234_code", 32'(cmd_code), 32'd3);
    checkOutput("t1234_tx_count", 32'(tx_count - tx_before), 32'd1);

    // Lower-case RUN then STOP
    valid_before = valid_seen;
    tx_before = tx_count;
    sendText("r", 8'h0A, 1);
    sendText("S", 8'h0D, 1);
    idle(12);
    checkOutput("rs_valid_count", 32'(valid_seen - valid_before), 32'd2);
    checkOutput("rs_code", 32'(cmd_code), 32'd1);
    checkOutput("rs_tx_count_min", 32'(tx_count - tx_before >= 1), 32'd1);

    // Digit overflow, then CLEAR
    err_before = err_seen;
    valid_before = valid_seen;
    sendText("T12345", 8'h0D, 0);
    idle(8);
    checkOutput("ovf_err_count", 32'(err_seen - err_before), 32'd1);
    checkOutput("ovf_valid_count", 32'(valid_seen - valid_before), 32'd0);
    sendText("C", 8'h0D, 0);
    idle(8);
    checkOutput("clear_code", 32'(cmd_code), 32'd2);
    checkOutput("clear_arg", 32'(cmd_arg), 32'd0);

    // Three malformed lines
    err_before = err_seen;
    sendText("X9", 8'h0D, 0);
    sendText("R5", 8'h0D, 0);
    sendText("T", 8'h0D, 0);
    idle(10);
    checkOutput("bad_err_count", 32'(err_seen - err_before), 32'd3);
    checkOutput("bad_code_held", 32'(cmd_code), 32'd2);

    // Transmitter held busy: nothing is sent until it frees up
    force_busy = 1'b1;
    busy_cnt = 0;
    idle(3);
    tx_before = tx_count;
    sendText("R", 8'h0D, 0);
    sendText("S", 8'h0D, 0);
    idle(5);
    checkOutput("busy_no_tx", 32'(tx_count - tx_before), 32'd0);
    force_busy = 1'b0;
    idle(10);
    checkOutput("busy_one_tx", 32'(tx_count - tx_before), 32'd1);

    // Reset in the middle of a line
    sendText("T1", 8'h32, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    sendText("C", 8'h0D, 0);
    idle(8);
    checkOutput("post_reset_code", 32'(cmd_code), 32'd2);

    // Random traffic
    for (int n = 0; n < 300; n++) randomLine();

    // Drain: every newest response must eventually go out
    force_busy = 1'b0;
    busy_cnt = 0;
    idle(30);
    checkOutput("all_sent", 32'(next_unsent), 32'(resp_byte.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
